tx_link_seq: RTL and testbench

//  JESD204B TX link-layer sequencer for one lane, 4 octets per CLK beat, downstream of the LMFC generator.

---
 rtl/tx_link_seq.sv | 155 +++++++++++++++
 tb/tb_tx_link_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/tx_link_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tx_link_seq : JESD204B TX link-layer sequencer, CGS -> ILAS -> DATA,      |
// |               one lane, 4 octets per beat.      Rev 1.0                   |
// +--------------------------------------------------------------------------+
module tx_link_seq #(
  parameter int RESYNC_CYC = 8
) (
  input  logic         CLK,
  input  logic         RST_n,
  input  logic         EN,
  input  logic         SYNC_n,
  input  logic         SYNCED,
  input  logic [3:0]   MS,
  input  logic [3:0]   ME,
  input  logic [111:0] CFG,
  input  logic [31:0]  TX_DATA,
  output logic         TX_READY,
  output logic [31:0]  DOUT,
  output logic [3:0]   KOUT,
  output logic [1:0]   STATE,
  output logic [1:0]   ILAS_MF
);

  typedef enum logic [1:0] {
    ST_CGS  = 2'b00,
    ST_WAIT = 2'b01,
    ST_ILAS = 2'b10,
    ST_DATA = 2'b11
  } state_t;

  localparam logic [7:0]  RS_LIM = 8'(RESYNC_CYC);
  localparam logic [31:0] K_BEAT = 32'hBCBCBCBC;

  state_t      state, state_nx;
  logic [1:0]  ilas_mf, mf_nx, mf_cur;
  logic [7:0]  beat_cnt, beat_nx, beat_idx;
  logic [7:0]  rs_cnt, rs_nx, rs_inc;
  logic        rs_hit, ilas_go;
  logic [31:0] dout, dout_nx, ilas_dout;
  logic [3:0]  kout, kout_nx, ilas_kout;
  logic [127:0] cfg_ext;
  logic [7:0]  oct_n, oct_v;
  logic        oct_k;
  logic [3:0]  cfg_idx;
  logic        unused_ms_me;

  assign unused_ms_me = &{1'b0, MS[3:1], ME[2:0]};

  // Zero-padded so any 4-bit config index stays inside the vector.
  assign cfg_ext  = {16'h0000, CFG};
  assign beat_idx = MS[0] ? 8'd0 : beat_cnt;
  assign mf_cur   = (state == ST_ILAS) ? ilas_mf : 2'd0;
  assign rs_inc   = (rs_cnt == 8'hFF) ? 8'hFF : rs_cnt + 8'd1;
  assign rs_hit   = !SYNC_n && (rs_inc >= RS_LIM);

  always_comb begin
    ilas_dout = '0;
    ilas_kout = '0;
    oct_n     = '0;
    oct_v     = '0;
    oct_k     = 1'b0;
    cfg_idx   = '0;
    for (int i = 0; i < 4; i++) begin
      oct_n   = {beat_idx[5:0], 2'(i)};
      cfg_idx = oct_n[3:0] - 4'd2;
      oct_v   = oct_n;
      oct_k   = 1'b0;
      if (oct_n == 8'd0) begin
        oct_v = 8'h1C;
        oct_k = 1'b1;
      end else if (mf_cur == 2'd1 && oct_n == 8'd1) begin
        oct_v = 8'h9C;
        oct_k = 1'b1;
      end else if (mf_cur == 2'd1 && oct_n <= 8'd15) begin
        oct_v = cfg_ext[{cfg_idx, 3'b000} +: 8];
      end
      // /A/ wins over config when the multiframe is too short to hold C13.
      if (i == 3 && ME[3]) begin
        oct_v = 8'h7C;
        oct_k = 1'b1;
      end
      ilas_dout[8*i +: 8] = oct_v;
      ilas_kout[i]        = oct_k;
    end
  end

  always_comb begin
    state_nx = state;
    mf_nx    = ilas_mf;
    beat_nx  = beat_cnt;
    rs_nx    = 8'd0;
    dout_nx  = K_BEAT;
    kout_nx  = 4'hF;
    ilas_go  = 1'b0;
    case (state)
      ST_CGS: begin
        if (SYNC_n && SYNCED) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (!SYNCED || !SYNC_n) state_nx = ST_CGS;
        else if (MS[0])         ilas_go  = 1'b1;
      end
      default: begin
        rs_nx = SYNC_n ? 8'd0 : rs_inc;
        if (!SYNCED || rs_hit) begin
          state_nx = ST_CGS;
          rs_nx    = 8'd0;
        end else if (state == ST_ILAS) begin
          ilas_go = 1'b1;
        end else begin
          dout_nx = TX_DATA;
          kout_nx = 4'h0;
        end
      end
    endcase
    if (ilas_go) begin
      dout_nx  = ilas_dout;
      kout_nx  = ilas_kout;
      beat_nx  = beat_idx + 8'd1;
      state_nx = ST_ILAS;
      mf_nx    = mf_cur;
      if (ME[3]) begin
        if (mf_cur == 2'd3) state_nx = ST_DATA;
        else                mf_nx    = mf_cur + 2'd1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_n) begin
      state    <= ST_CGS;
      ilas_mf  <= 2'd0;
      beat_cnt <= 8'd0;
      rs_cnt   <= 8'd0;
      dout     <= K_BEAT;
      kout     <= 4'hF;
    end else if (EN) begin
      state    <= state_nx;
      ilas_mf  <= mf_nx;
      beat_cnt <= beat_nx;
      rs_cnt   <= rs_nx;
      dout     <= dout_nx;
      kout     <= kout_nx;
    end
  end

  assign TX_READY = (state == ST_DATA) && EN;
  assign DOUT     = dout;
  assign KOUT     = kout;
  assign STATE    = state;
  assign ILAS_MF  = ilas_mf;

endmodule
`default_nettype wire

// File: tb/tb_tx_link_seq.sv
`default_nettype none
// Directed, table-driven bench for tx_link_seq: CGS, ILAS at LMFC 8 and 4,
// DATA, resync threshold, SYNCED loss, EN gating and mid-ILAS reset.
module tb_tx_link_seq;
  localparam int RC = 8;

  logic         CLK = 1'b0;
  logic         RST_n, EN, SYNC_n, SYNCED;
  logic [3:0]   MS, ME;
  logic [111:0] CFG;
  logic [31:0]  TX_DATA;
  logic         TX_READY;
  logic [31:0]  DOUT;
  logic [3:0]   KOUT;
  logic [1:0]   STATE, ILAS_MF;

  tx_link_seq #(.RESYNC_CYC(RC)) dut (
    .CLK(CLK), .RST_n(RST_n), .EN(EN), .SYNC_n(SYNC_n), .SYNCED(SYNCED),
    .MS(MS), .ME(ME), .CFG(CFG), .TX_DATA(TX_DATA), .TX_READY(TX_READY),
    .DOUT(DOUT), .KOUT(KOUT), .STATE(STATE), .ILAS_MF(ILAS_MF)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        sn;
    logic        sy;
    logic        ms;
    logic        me;
    logic [31:0] dout;
    logic [3:0]  kout;
    logic [1:0]  st;
  } vec_t;

  vec_t        tbl [10];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        rdy_s;
  logic [7:0]  m_oct [128];
  logic        m_k   [128];
  logic [31:0] cap_d [32];
  logic [3:0]  cap_k [32];
  logic [31:0] td;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Inputs held for one cycle; TX_READY sampled mid-cycle, registered outputs 1 ns after the edge.
  task automatic step(input logic en, input logic sn, input logic sy,
                      input logic ms0, input logic me3, input logic [31:0] d);
    EN = en; SYNC_n = sn; SYNCED = sy;
    MS = {3'b000, ms0}; ME = {me3, 3'b000}; TX_DATA = d;
    @(negedge CLK);
    rdy_s = TX_READY;
    @(posedge CLK);
    #1;
  endtask

  // Whole 4-multiframe ILAS as an octet stream, later rules overwriting earlier ones.
  task automatic build_model(input int L);
    int mfl;
    mfl = 4 * L;
    for (int j = 0; j < 4 * mfl; j++) begin
      m_oct[j] = 8'(j % mfl);
      m_k[j]   = 1'b0;
    end
    for (int mf = 0; mf < 4; mf++) begin
      m_oct[mf*mfl] = 8'h1C;
      m_k[mf*mfl]   = 1'b1;
    end
    m_oct[mfl+1] = 8'h9C;
    m_k[mfl+1]   = 1'b1;
    for (int c = 0; c < 14; c++) begin
      if (c + 2 < mfl) begin
        m_oct[mfl+2+c] = CFG[8*c +: 8];
        m_k[mfl+2+c]   = 1'b0;
      end
    end
    for (int mf = 0; mf < 4; mf++) begin
      m_oct[mf*mfl+mfl-1] = 8'h7C;
      m_k[mf*mfl+mfl-1]   = 1'b1;
    end
  endtask

  task automatic ilas_beats(input int L, input int b0, input int b1, input bit tog);
    int mf, pos, base, emf, est;
    logic [31:0] ed, pd;
    logic [3:0]  ek, pk;
    int ps;
    build_model(L);
    pd = 32'hBCBCBCBC; pk = 4'hF; ps = 1;
    for (int b = b0; b <= b1; b++) begin
      mf = b / L; pos = b % L; base = b * 4;
      if (tog) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
        chk($sformatf("frz_rdy b%0d", b), rdy_s, 0);
        chk($sformatf("frz_dout b%0d", b), DOUT, pd);
        chk($sformatf("frz_kout b%0d", b), KOUT, pk);
        chk($sformatf("frz_state b%0d", b), STATE, ps);
      end
      step(1'b1, 1'b1, 1'b1, pos == 0, pos == L - 1, $urandom);
      ed = {m_oct[base+3], m_oct[base+2], m_oct[base+1], m_oct[base]};
      ek = {m_k[base+3], m_k[base+2], m_k[base+1], m_k[base]};
      est = (b == 4 * L - 1) ? 3 : 2;
      emf = (b == 4 * L - 1) ? 3 : ((pos == L - 1) ? mf + 1 : mf);
      cap_d[b] = DOUT;
      cap_k[b] = KOUT;
      chk($sformatf("ilas_rdy b%0d", b), rdy_s, 0);
      chk($sformatf("ilas_dout L%0d b%0d", L, b), DOUT, ed);
      chk($sformatf("ilas_kout L%0d b%0d", L, b), KOUT, ek);
      chk($sformatf("ilas_state L%0d b%0d", L, b), STATE, est);
      chk($sformatf("ilas_mf L%0d b%0d", L, b), ILAS_MF, emf);
      pd = ed; pk = ek; ps = est;
    end
  endtask

  initial begin
    CFG = '0;
    for (int c = 0; c < 14; c++) CFG[8*c +: 8] = 8'hA0 + 8'(c);

    RST_n = 1'b0;
    step(1, 0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 1, 1, 32'h0);
    chk("rst_dout", DOUT, 32'hBCBCBCBC);
    chk("rst_kout", KOUT, 4'hF);
    chk("rst_state", STATE, 2'd0);
    chk("rst_mf", ILAS_MF, 2'd0);
    RST_n = 1'b1;

    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd0};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'hBCBCBCBC, 4'hF, 2'd0};
    tbl[2] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd0};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd0};
    tbl[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hBCBCBCBC, 4'hF, 2'd1};
    tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0302011C, 4'h1, 2'd2};
    for (int i = 0; i < 10; i++) begin
      step(1, tbl[i].sn, tbl[i].sy, tbl[i].ms, tbl[i].me, 32'h0);
      chk($sformatf("tbl_rdy %0d", i), rdy_s, 0);
      chk($sformatf("tbl_dout %0d", i), DOUT, tbl[i].dout);
      chk($sformatf("tbl_kout %0d", i), KOUT, tbl[i].kout);
      chk($sformatf("tbl_state %0d", i), STATE, tbl[i].st);
    end

    // LMFC of 8 beats, beat 0 already produced by the last table row.
    ilas_beats(8, 1, 31, 1'b0);
    chk("l8_mf0_b7_dout", cap_d[7], 32'h7C1E1D1C);
    chk("l8_mf0_b7_kout", cap_k[7], 4'h8);
    chk("l8_mf1_b0_dout", cap_d[8], 32'hA1A09C1C);
    chk("l8_mf1_b0_kout", cap_k[8], 4'h3);
    chk("l8_mf1_b1_dout", cap_d[9], 32'hA5A4A3A2);

    for (int k = 0; k < 3; k++) begin
      td = $urandom;
      step(1, 1, 1, 0, 0, td);
      chk("data_rdy", rdy_s, 1);
      chk("data_dout", DOUT, td);
      chk("data_kout", KOUT, 4'h0);
      chk("data_state", STATE, 2'd3);
    end

    for (int k = 0; k < RC - 1; k++) begin
      td = $urandom;
      step(1, 0, 1, 0, 0, td);
      chk($sformatf("short_dout %0d", k), DOUT, td);
      chk($sformatf("short_state %0d", k), STATE, 2'd3);
    end
    td = $urandom;
    step(1, 1, 1, 0, 0, td);
    chk("short_end_dout", DOUT, td);
    chk("short_end_state", STATE, 2'd3);

    for (int k = 0; k < RC; k++) begin
      td = $urandom;
      step(1, 0, 1, 0, 0, td);
      if (k < RC - 1) begin
        chk($sformatf("long_dout %0d", k), DOUT, td);
        chk($sformatf("long_state %0d", k), STATE, 2'd3);
      end else begin
        chk("resync_dout", DOUT, 32'hBCBCBCBC);
        chk("resync_kout", KOUT, 4'hF);
        chk("resync_state", STATE, 2'd0);
      end
    end

    step(1, 1, 0, 1, 0, 32'h0);
    chk("nosync_state0", STATE, 2'd0);
    step(1, 1, 0, 0, 0, 32'h0);
    chk("nosync_state1", STATE, 2'd0);
    step(1, 1, 1, 0, 0, 32'h0);
    chk("synced_wait", STATE, 2'd1);
    step(1, 1, 1, 0, 0, 32'h0);
    chk("synced_wait2", STATE, 2'd1);

    // LMFC of 4 beats: C13 is displaced by /A/.
    ilas_beats(4, 0, 15, 1'b0);
    chk("l4_mf1_b3_dout", cap_d[7], 32'h7CACABAA);
    chk("l4_mf1_b3_kout", cap_k[7], 4'h8);
    for (int mf = 0; mf < 4; mf++) begin
      chk($sformatf("l4_end_A mf%0d", mf), {24'h0, cap_d[4*mf+3][31:24]}, 32'h7C);
      chk($sformatf("l4_end_K mf%0d", mf), {31'h0, cap_k[4*mf+3][3]}, 32'h1);
    end

    td = $urandom;
    step(1, 1, 0, 0, 0, td);
    chk("loss_dout", DOUT, 32'hBCBCBCBC);
    chk("loss_state", STATE, 2'd0);
    step(1, 1, 1, 0, 0, 32'h0);
    chk("resync_wait", STATE, 2'd1);

    // EN gated every other cycle, then reset in the middle of MF2.
    ilas_beats(8, 0, 17, 1'b1);
    RST_n = 1'b0;
    step(1, 1, 1, 0, 0, 32'h0);
    RST_n = 1'b1;
    chk("midrst_dout", DOUT, 32'hBCBCBCBC);
    chk("midrst_kout", KOUT, 4'hF);
    chk("midrst_state", STATE, 2'd0);
    chk("midrst_mf", ILAS_MF, 2'd0);
    step(1, 0, 1, 1, 0, 32'h0);
    chk("post_rst_state", STATE, 2'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
